// File: rtl/fault_inject_sched.sv
// Fault-injection scheduler: counts core run cycles after arming, then stalls the core and
// does one read-modify-write on the register file. Optional FI_STUCK_AT_EN adds stuck-at modes.
module fault_inject_sched #(
    parameter int COUNT_WIDTH   = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   cpu_running,
    input  logic                   cfg_arm,
    input  logic                   cfg_abort,
    input  logic [COUNT_WIDTH-1:0] cfg_target_cycle,
    input  logic [4:0]             cfg_reg_addr,
    input  logic [31:0]            cfg_mask,
    input  logic [1:0]             cfg_mode,
    output logic                   fi_stall_req,
    output logic [4:0]             regfile_addr,
    input  logic [31:0]            regfile_read_data,
    output logic                   regfile_write_enable,
    output logic [31:0]            regfile_write_data,
    output logic                   fi_busy,
    output logic                   fi_done,
    output logic                   fi_error,
    output logic [31:0]            fi_orig_value,
    output logic [COUNT_WIDTH-1:0] fi_cycle_count
);

    typedef enum logic [2:0] {IDLE, ARMED, SETTLE, READ, WRITE, RELEASE} state_t;

    state_t                 state_reg;
    logic [COUNT_WIDTH-1:0] target_reg;
    logic [4:0]             addr_reg;
    logic [31:0]            mask_reg;
    logic [3:0]             settle_reg;
    logic [31:0]            inject_data;
    logic                   invalid;

`ifdef FI_STUCK_AT_EN
    logic [1:0] mode_reg;

    always_comb begin
        case (mode_reg)
            2'd1:    inject_data = regfile_read_data | mask_reg;
            2'd2:    inject_data = regfile_read_data & ~mask_reg;
            default: inject_data = regfile_read_data ^ mask_reg;
        endcase
        // Mode 3 is reserved: treated like a bad target, so no access happens.
        invalid = (addr_reg == 5'd0) || (mode_reg == 2'd3);
    end
`else
    logic [1:0] unused_mode;
    assign unused_mode = cfg_mode;

    always_comb begin
        inject_data = regfile_read_data ^ mask_reg;
        invalid     = (addr_reg == 5'd0);
    end
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg            <= IDLE;
            target_reg           <= '0;
            addr_reg             <= '0;
            mask_reg             <= '0;
`ifdef FI_STUCK_AT_EN
            mode_reg             <= '0;
`endif
            settle_reg           <= '0;
            fi_cycle_count       <= '0;
            fi_stall_req         <= 1'b0;
            regfile_addr         <= '0;
            regfile_write_enable <= 1'b0;
            regfile_write_data   <= '0;
            fi_busy              <= 1'b0;
            fi_done              <= 1'b0;
            fi_error             <= 1'b0;
            fi_orig_value        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cfg_arm) begin
                        target_reg     <= cfg_target_cycle;
                        addr_reg       <= cfg_reg_addr;
                        mask_reg       <= cfg_mask;
`ifdef FI_STUCK_AT_EN
                        mode_reg       <= cfg_mode;
`endif
                        fi_cycle_count <= '0;
                        fi_done        <= 1'b0;
                        fi_error       <= 1'b0;
                        fi_busy        <= 1'b1;
                        state_reg      <= ARMED;
                    end
                end
                ARMED: begin
                    // Equality is checked before incrementing, so the counter freezes at target.
                    if (cfg_abort) begin
                        fi_busy   <= 1'b0;
                        state_reg <= IDLE;
                    end else if (fi_cycle_count == target_reg) begin
                        fi_stall_req <= 1'b1;
                        settle_reg   <= '0;
                        state_reg    <= SETTLE;
                    end else if (cpu_running) begin
                        fi_cycle_count <= fi_cycle_count + COUNT_WIDTH'(1);
                    end
                end
                SETTLE: begin
                    if (settle_reg == 4'(SETTLE_CYCLES - 1)) begin
                        if (invalid) begin
                            state_reg <= RELEASE;
                        end else begin
                            regfile_addr <= addr_reg;
                            state_reg    <= READ;
                        end
                    end else begin
                        settle_reg <= settle_reg + 4'd1;
                    end
                end
                READ: begin
                    fi_orig_value        <= regfile_read_data;
                    regfile_write_data   <= inject_data;
                    regfile_write_enable <= 1'b1;
                    state_reg            <= WRITE;
                end
                WRITE: begin
                    regfile_addr         <= '0;
                    regfile_write_data   <= '0;
                    regfile_write_enable <= 1'b0;
                    state_reg            <= RELEASE;
                end
                RELEASE: begin
                    fi_stall_req <= 1'b0;
                    fi_done      <= 1'b1;
                    fi_error     <= invalid;
                    fi_busy      <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fault_inject_sched.sv
// Self-checking bench for fault_inject_sched: timeline model of the injection sequence,
// a register file model, and directed scenarios with literal expectations.
module tb_fault_inject_sched;

    localparam int S = 2;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        cpu_running = 1'b0;
    logic        cfg_arm = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [31:0] cfg_target_cycle = '0;
    logic [4:0]  cfg_reg_addr = '0;
    logic [31:0] cfg_mask = '0;
    logic [1:0]  cfg_mode = '0;
    logic        fi_stall_req;
    logic [4:0]  regfile_addr;
    logic [31:0] regfile_read_data;
    logic        regfile_write_enable;
    logic [31:0] regfile_write_data;
    logic        fi_busy;
    logic        fi_done;
    logic        fi_error;
    logic [31:0] fi_orig_value;
    logic [31:0] fi_cycle_count;

    always #5 CLK = ~CLK;

    fault_inject_sched #(.COUNT_WIDTH(32), .SETTLE_CYCLES(S)) dut (
        .CLK(CLK),
        .RSTn(RSTn),
        .cpu_running(cpu_running),
        .cfg_arm(cfg_arm),
        .cfg_abort(cfg_abort),
        .cfg_target_cycle(cfg_target_cycle),
        .cfg_reg_addr(cfg_reg_addr),
        .cfg_mask(cfg_mask),
        .cfg_mode(cfg_mode),
        .fi_stall_req(fi_stall_req),
        .regfile_addr(regfile_addr),
        .regfile_read_data(regfile_read_data),
        .regfile_write_enable(regfile_write_enable),
        .regfile_write_data(regfile_write_data),
        .fi_busy(fi_busy),
        .fi_done(fi_done),
        .fi_error(fi_error),
        .fi_orig_value(fi_orig_value),
        .fi_cycle_count(fi_cycle_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Register file seen by the DUT; preloads and clears go through the same process.
    logic [31:0] tb_rf [32];
    logic        pl_en = 1'b0;
    logic        rf_clr = 1'b0;
    logic [4:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          wr_count = 0;

    assign regfile_read_data = (regfile_addr == 5'd0) ? 32'd0 : tb_rf[regfile_addr];

    always @(posedge CLK) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) tb_rf[i] <= 32'd0;
        end
        if (pl_en) tb_rf[pl_addr] <= pl_data;
        if (regfile_write_enable) begin
            tb_rf[regfile_addr] <= regfile_write_data;
            wr_count++;
        end
    end

    function automatic logic [31:0] fault_value(input logic [31:0] v, input logic [31:0] m,
                                                input logic [1:0] mode);
`ifdef FI_STUCK_AT_EN
        case (mode)
            2'd1:    return v | m;
            2'd2:    return v & ~m;
            default: return v ^ m;
        endcase
`else
        return v ^ m + 32'd0 * {30'd0, mode};
`endif
    endfunction

    // Timeline model: phase 0 idle, 1 waiting for target, 2 injecting (k = edges since firing).
    int          m_phase;
    int          m_k;
    logic [31:0] m_cnt, m_target, m_mask, m_orig, m_wdata;
    logic [4:0]  m_addr;
    logic [1:0]  m_mode;
    logic        m_done, m_err, m_bad;
    logic [31:0] m_rf [32];

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m_phase = 0; m_k = 0; m_cnt = 0; m_target = 0; m_mask = 0; m_orig = 0;
            m_wdata = 0; m_addr = 0; m_mode = 0; m_done = 0; m_err = 0; m_bad = 0;
        end else begin
            if (rf_clr) for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            if (pl_en) m_rf[pl_addr] = pl_data;
            case (m_phase)
                0: if (cfg_arm) begin
                    m_target = cfg_target_cycle; m_addr = cfg_reg_addr;
                    m_mask = cfg_mask; m_mode = cfg_mode;
                    m_cnt = 0; m_done = 0; m_err = 0; m_phase = 1;
`ifdef FI_STUCK_AT_EN
                    m_bad = (cfg_reg_addr == 0) || (cfg_mode == 2'd3);
`else
                    m_bad = (cfg_reg_addr == 0);
`endif
                end
                1: begin
                    if (cfg_abort) m_phase = 0;
                    else if (m_cnt == m_target) begin m_phase = 2; m_k = 0; end
                    else if (cpu_running) m_cnt = m_cnt + 1;
                end
                default: begin
                    m_k++;
                    if (m_bad) begin
                        if (m_k == S + 1) begin m_done = 1; m_err = 1; m_phase = 0; end
                    end else begin
                        if (m_k == S + 1) begin
                            m_orig  = m_rf[m_addr];
                            m_wdata = fault_value(m_orig, m_mask, m_mode);
                        end
                        if (m_k == S + 2) m_rf[m_addr] = m_wdata;
                        if (m_k == S + 3) begin m_done = 1; m_phase = 0; end
                    end
                end
            endcase
        end
    end

    logic        e_we;
    logic [4:0]  e_addr;

    always @(negedge CLK) begin
        if (RSTn) begin
            e_we   = (m_phase == 2) && !m_bad && (m_k == S + 1);
            e_addr = ((m_phase == 2) && !m_bad && (m_k == S || m_k == S + 1)) ? m_addr : 5'd0;
            chk("cyc_stall", fi_stall_req, m_phase == 2);
            chk("cyc_we", regfile_write_enable, e_we);
            chk("cyc_addr", regfile_addr, e_addr);
            chk("cyc_wdata", regfile_write_data, e_we ? m_wdata : 32'd0);
            chk("cyc_busy", fi_busy, m_phase != 0);
            chk("cyc_done", fi_done, m_done);
            chk("cyc_error", fi_error, m_err);
            chk("cyc_count", fi_cycle_count, m_cnt);
            chk("cyc_orig", fi_orig_value, m_orig);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic arm(input logic [31:0] tgt, input logic [4:0] a, input logic [31:0] m,
                       input logic [1:0] mode, input logic ab);
        cfg_target_cycle = tgt; cfg_reg_addr = a; cfg_mask = m; cfg_mode = mode;
        cfg_arm = 1'b1; cfg_abort = ab;
        tick();
        cfg_arm = 1'b0; cfg_abort = 1'b0;
    endtask

    task automatic wait_stall(input bit toggle, output int edges);
        edges = -1;
        for (int n = 1; n <= 400; n++) begin
            tick();
            if (fi_stall_req) begin
                edges = n;
                return;
            end
            if (toggle) cpu_running = ~cpu_running;
        end
        chk("stall_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 50; n++) begin
            tick();
            if (!fi_busy) return;
        end
        chk("idle_timeout", 64'd1, 64'd0);
    endtask

    int e;
    int w0;

    initial begin
        #3;
        chk("rst_stall", fi_stall_req, 1'b0);
        chk("rst_busy", fi_busy, 1'b0);
        chk("rst_done", fi_done, 1'b0);
        chk("rst_count", fi_cycle_count, 32'd0);
        chk("rst_we", regfile_write_enable, 1'b0);
        #20;
        tick();
        RSTn = 1'b1;
        rf_clr = 1'b1;
        tick();
        rf_clr = 1'b0;

        // 1: running continuously, target 10
        preload(5'd5, 32'h12345678);
        cpu_running = 1'b1;
        w0 = wr_count;
        arm(32'd10, 5'd5, 32'h1, 2'd0, 1'b0);
        wait_stall(1'b0, e);
        chk("t1_fire_edges", e, 11);
        chk("t1_count", fi_cycle_count, 32'd10);
        wait_idle();
        chk("t1_x5", tb_rf[5], 32'h12345679);
        chk("t1_orig", fi_orig_value, 32'h12345678);
        chk("t1_done", fi_done, 1'b1);
        chk("t1_writes", wr_count - w0, 1);
        $display("txn 1: target=10 reg=5 fire_edges=%0d x5=0x%08h", e, tb_rf[5]);

        // 2: cpu_running alternates, target 4
        preload(5'd9, 32'h000000A5);
        arm(32'd4, 5'd9, 32'h100, 2'd0, 1'b0);
        cpu_running = 1'b1;
        wait_stall(1'b1, e);
        chk("t2_fire_edges", e, 8);
        chk("t2_count", fi_cycle_count, 32'd4);
        cpu_running = 1'b1;
        wait_idle();
        chk("t2_x9", tb_rf[9], 32'h000001A5);
        $display("txn 2: target=4 toggled fire_edges=%0d x9=0x%08h", e, tb_rf[9]);

        // 3: target 0 fires immediately even with the core halted
        preload(5'd3, 32'h0);
        cpu_running = 1'b0;
        arm(32'd0, 5'd3, 32'hFFFFFFFF, 2'd0, 1'b0);
        wait_stall(1'b0, e);
        chk("t3_fire_edges", e, 1);
        wait_idle();
        chk("t3_x3", tb_rf[3], 32'hFFFFFFFF);
        $display("txn 3: target=0 reg=3 fire_edges=%0d x3=0x%08h", e, tb_rf[3]);

        // 4: register 0 is rejected without touching the register file
        w0 = wr_count;
        cpu_running = 1'b1;
        arm(32'd5, 5'd0, 32'h1, 2'd0, 1'b0);
        wait_stall(1'b0, e);
        wait_idle();
        chk("t4_writes", wr_count - w0, 0);
        chk("t4_error", fi_error, 1'b1);
        chk("t4_done", fi_done, 1'b1);
        chk("t4_stall", fi_stall_req, 1'b0);
        $display("txn 4: reg=0 error=%0b done=%0b", fi_error, fi_done);

        // 5: abort at count 20, then rearm with arm and abort together
        preload(5'd6, 32'h55);
        w0 = wr_count;
        arm(32'd100, 5'd6, 32'h0F, 2'd0, 1'b0);
        chk("t5_err_cleared", fi_error, 1'b0);
        for (int n = 0; n < 60 && fi_cycle_count != 32'd20; n++) tick();
        chk("t5_reach20", fi_cycle_count, 32'd20);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("t5_busy", fi_busy, 1'b0);
        tick(); tick();
        chk("t5_stall", fi_stall_req, 1'b0);
        chk("t5_writes", wr_count - w0, 0);
        chk("t5_done", fi_done, 1'b0);
        arm(32'd2, 5'd6, 32'h0F, 2'd0, 1'b1);
        chk("t5_rearm_busy", fi_busy, 1'b1);
        wait_stall(1'b0, e);
        wait_idle();
        chk("t5_x6", tb_rf[6], 32'h5A);
        $display("txn 5: abort then rearm x6=0x%08h", tb_rf[6]);

        // 6: reset during SETTLE, then a stuck-at-0 (or flip) injection on x7
        preload(5'd7, 32'hFF);
        w0 = wr_count;
        arm(32'd3, 5'd7, 32'hF0, 2'd2, 1'b0);
        wait_stall(1'b0, e);
        tick();
        #2 RSTn = 1'b0;
        #1;
        chk("t6_rst_stall", fi_stall_req, 1'b0);
        chk("t6_rst_busy", fi_busy, 1'b0);
        chk("t6_rst_we", regfile_write_enable, 1'b0);
        tick(); tick();
        RSTn = 1'b1;
        tick();
        chk("t6_rst_writes", wr_count - w0, 0);
        chk("t6_x7_kept", tb_rf[7], 32'hFF);
        arm(32'd3, 5'd7, 32'hF0, 2'd2, 1'b0);
        wait_stall(1'b0, e);
        wait_idle();
        chk("t6_x7", tb_rf[7], 32'h0F);
        $display("txn 6: reset mid-settle, then x7=0x%08h", tb_rf[7]);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
